// File: rtl/apbspi_spi_master.sv
// SPI master shift engine: pops TX words, serialises one frame per word under
// CPOL/CPHA/prescaler control, and pushes the deserialised MISO word to the RX FIFO.
module apbspi_spi_master #(
  parameter int FRAME_WIDTH = 8,
  parameter int PRESC_WIDTH = 32
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   spi_enable,
  input  logic [PRESC_WIDTH-1:0] spi_prescaler,
  input  logic                   spi_cpol,
  input  logic                   spi_cpha,
  input  logic                   tx_fifo_empty,
  input  logic [31:0]            tx_fifo_read_data,
  output logic                   tx_fifo_pop,
  input  logic                   rx_fifo_full,
  output logic [31:0]            rx_fifo_write_data,
  output logic                   rx_fifo_push,
  output logic                   spi_busy,
  output logic                   spi_trx_done,
  output logic                   rx_overflow,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  input  logic                   spi_miso,
  output logic                   spi_cs_n
);

  // Handshake: tx_fifo_pop / rx_fifo_push are single-cycle strobes; the TX head
  // word is consumed (latched) in the IDLE cycle that raises the pop strobe.
  localparam int CW = PRESC_WIDTH + 1;
  localparam logic [6:0] LAST_EDGE = 7'(2 * FRAME_WIDTH - 1);

  typedef logic [FRAME_WIDTH-1:0] frame_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_END} state_t;

  state_t        state, next_state;
  frame_t        tx_sh, rx_sh;
  logic          cpol_q, cpha_q;
  logic [CW-1:0] h_q, cnt;
  logic [6:0]    edge_cnt;

  logic start, edge_tick, last_edge, odd_edge;

  always_comb begin
    next_state = state;
    start      = spi_enable && !tx_fifo_empty;
    edge_tick  = (cnt == h_q);
    last_edge  = edge_tick && (edge_cnt == LAST_EDGE);
    odd_edge   = !edge_cnt[0];
    case (state)
      ST_IDLE:  if (start) next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (!spi_enable)    next_state = ST_IDLE;
        else if (last_edge) next_state = ST_END;
      end
      ST_END: begin
        if (!spi_enable)    next_state = ST_IDLE;
        else if (edge_tick) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state              <= ST_IDLE;
      tx_fifo_pop        <= 1'b0;
      rx_fifo_push       <= 1'b0;
      rx_fifo_write_data <= '0;
      spi_busy           <= 1'b0;
      spi_trx_done       <= 1'b0;
      rx_overflow        <= 1'b0;
      spi_cs_n           <= 1'b1;
      spi_sclk           <= 1'b0;
      spi_mosi           <= 1'b0;
      tx_sh              <= '0;
      rx_sh              <= '0;
      cpol_q             <= 1'b0;
      cpha_q             <= 1'b0;
      h_q                <= CW'(1);
      cnt                <= CW'(1);
      edge_cnt           <= '0;
    end else begin
      state        <= next_state;
      tx_fifo_pop  <= 1'b0;
      rx_fifo_push <= 1'b0;
      spi_trx_done <= 1'b0;
      rx_overflow  <= 1'b0;
      case (state)
        ST_IDLE: begin
          spi_sclk <= spi_cpol;
          spi_cs_n <= 1'b1;
          spi_busy <= 1'b0;
          spi_mosi <= 1'b0;
          if (start) begin
            tx_fifo_pop <= 1'b1;
            cpol_q      <= spi_cpol;
            cpha_q      <= spi_cpha;
            h_q         <= {1'b0, spi_prescaler} + CW'(1);
            cnt         <= CW'(1);
            edge_cnt    <= '0;
            spi_cs_n    <= 1'b0;
            spi_busy    <= 1'b1;
            // CPHA=0 presents the MSB with CS; CPHA=1 waits for edge 1.
            if (spi_cpha) begin
              tx_sh <= tx_fifo_read_data[FRAME_WIDTH-1:0];
            end else begin
              spi_mosi <= tx_fifo_read_data[FRAME_WIDTH-1];
              tx_sh    <= tx_fifo_read_data[FRAME_WIDTH-1:0] << 1;
            end
          end
        end
        ST_SHIFT: begin
          if (!spi_enable) begin
            spi_cs_n <= 1'b1;
            spi_busy <= 1'b0;
            spi_sclk <= cpol_q;
            spi_mosi <= 1'b0;
          end else if (edge_tick) begin
            cnt      <= CW'(1);
            edge_cnt <= edge_cnt + 7'd1;
            spi_sclk <= ~spi_sclk;
            if (cpha_q != odd_edge)
              rx_sh <= (rx_sh << 1) | frame_t'(spi_miso);
            if ((cpha_q && odd_edge) || (!cpha_q && !odd_edge && !last_edge)) begin
              spi_mosi <= tx_sh[FRAME_WIDTH-1];
              tx_sh    <= tx_sh << 1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_END: begin
          if (!spi_enable) begin
            spi_cs_n <= 1'b1;
            spi_busy <= 1'b0;
            spi_sclk <= cpol_q;
            spi_mosi <= 1'b0;
          end else if (edge_tick) begin
            spi_cs_n     <= 1'b1;
            spi_busy     <= 1'b0;
            spi_trx_done <= 1'b1;
            spi_mosi     <= 1'b0;
            spi_sclk     <= cpol_q;
            if (!rx_fifo_full) begin
              rx_fifo_push       <= 1'b1;
              rx_fifo_write_data <= 32'(rx_sh);
            end else begin
              rx_overflow <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: spi_cs_n <= 1'b1;
      endcase
    end
  end

endmodule
